// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and grant encoding for the register-file write-back scheduler.
package regfile_wb_scheduler_pkg;

  localparam int unsigned REG_ADDR_W          = 5;
  localparam int unsigned NUM_REGS            = 32;
  localparam int unsigned MAX_PENDING_DEFAULT = 4;
  localparam int unsigned PEND_CNT_W          = 4;

  typedef enum logic {
    GrantAlu = 1'b0,
    GrantLsu = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port (ALU vs LSU).
module wb_rr_arbiter
  import regfile_wb_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu_i,
  input  logic req_lsu_i,
  output logic gnt_alu_o,
  output logic gnt_lsu_o
);

  grant_e last_grant_q, last_grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GrantAlu;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    gnt_alu_o = 1'b0;
    gnt_lsu_o = 1'b0;
    if (req_alu_i && req_lsu_i) begin
      // On conflict, favour whichever side did not win last.
      if (last_grant_q == GrantAlu) begin
        gnt_lsu_o = 1'b1;
      end else begin
        gnt_alu_o = 1'b1;
      end
    end else begin
      gnt_alu_o = req_alu_i;
      gnt_lsu_o = req_lsu_i;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_alu_o) begin
      last_grant_d = GrantAlu;
    end else if (gnt_lsu_o) begin
      last_grant_d = GrantLsu;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Issue hazard scoreboard plus registered, arbitrated register-file write port.
// Optional macro SB_EARLY_CLEAR_EN lets issue see an LSU grant's busy clear in the grant cycle.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int unsigned MAX_PENDING = MAX_PENDING_DEFAULT,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  input  logic                  issue_long_i,
  input  logic [REG_ADDR_W-1:0] issue_rs1_i,
  input  logic [REG_ADDR_W-1:0] issue_rs2_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  output logic                  issue_ready_o,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0]     alu_data_i,
  output logic                  alu_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [DATA_W-1:0]     lsu_data_i,
  output logic                  lsu_ready_o,
  output logic                  wr_en_o,
  output logic [REG_ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0]     wr_data_o,
  output logic                  err_o
);

  logic [NUM_REGS-1:0]   busy_q, busy_d, busy_eff;
  logic [PEND_CNT_W-1:0] pending_q, pending_d, pending_eff;
  logic                  err_q, err_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  accept, long_inc;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_alu_i (alu_valid_i),
    .req_lsu_i (lsu_valid_i),
    .gnt_alu_o (alu_ready_o),
    .gnt_lsu_o (lsu_ready_o)
  );

  always_comb begin
    busy_eff    = busy_q;
    pending_eff = pending_q;
`ifdef SB_EARLY_CLEAR_EN
    if (lsu_ready_o) begin
      busy_eff[lsu_rd_i] = 1'b0;
      if (pending_q != '0) begin
        pending_eff = pending_q - 1'b1;
      end
    end
`endif
    issue_ready_o = !busy_eff[issue_rs1_i] && !busy_eff[issue_rs2_i] && !busy_eff[issue_rd_i] &&
                    !(issue_long_i && (pending_eff == PEND_CNT_W'(MAX_PENDING)));
  end

  assign accept   = issue_valid_i && issue_ready_o;
  assign long_inc = accept && issue_long_i;

  always_comb begin
    busy_d    = busy_q;
    pending_d = pending_q;
    err_d     = err_q;
    if (lsu_ready_o) begin
      busy_d[lsu_rd_i] = 1'b0;
    end
    // Set after clear so a new long op to the returning rd stays busy.
    if (long_inc && (issue_rd_i != '0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (lsu_ready_o && (pending_q == '0)) begin
      err_d = 1'b1;
    end
    if (long_inc && !lsu_ready_o) begin
      pending_d = pending_q + 1'b1;
    end else if (!long_inc && lsu_ready_o && (pending_q != '0)) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_ready_o) begin
      wr_en_d   = (alu_rd_i != '0);
      wr_addr_d = alu_rd_i;
      wr_data_d = alu_data_i;
    end else if (lsu_ready_o) begin
      wr_en_d   = (lsu_rd_i != '0);
      wr_addr_d = lsu_rd_i;
      wr_data_d = lsu_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: vector table plus directed hazard sequences.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid_i = 1'b0, issue_long_i = 1'b0;
  logic [4:0]  issue_rs1_i = '0, issue_rs2_i = '0, issue_rd_i = '0;
  logic        issue_ready_o;
  logic        alu_valid_i = 1'b0;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        alu_ready_o;
  logic        lsu_valid_i = 1'b0;
  logic [4:0]  lsu_rd_i = '0;
  logic [31:0] lsu_data_i = '0;
  logic        lsu_ready_o;
  logic        wr_en_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        ea;
    logic        el;
  } vec_t;

  wr_t         exp_q[$];
  logic [4:0]  hold_addr = '0;
  logic [31:0] hold_data = '0;
  vec_t        vecs[7];
  logic        early_exp;

  regfile_wb_scheduler #(
    .MAX_PENDING (4),
    .DATA_W      (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid_i),
    .issue_long_i  (issue_long_i),
    .issue_rs1_i   (issue_rs1_i),
    .issue_rs2_i   (issue_rs2_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .alu_valid_i   (alu_valid_i),
    .alu_rd_i      (alu_rd_i),
    .alu_data_i    (alu_data_i),
    .alu_ready_o   (alu_ready_o),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_rd_i      (lsu_rd_i),
    .lsu_data_i    (lsu_data_i),
    .lsu_ready_o   (lsu_ready_o),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    issue_valid_i = 1'b0; issue_long_i = 1'b0;
    issue_rs1_i = '0; issue_rs2_i = '0; issue_rd_i = '0;
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    exp_q.delete();
    hold_addr = '0;
    hold_data = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_ready(input string name, input logic exp);
    #1 chk(name, issue_ready_o, exp);
  endtask

  // One clock: check grants against expectation, queue the write, check the port after the edge.
  task automatic cyc(input logic ea, input logic el);
    wr_t e;
    #1;
    chk("alu_ready", alu_ready_o, ea);
    chk("lsu_ready", lsu_ready_o, el);
    if (ea) begin
      exp_q.push_back('{en: (alu_rd_i != 0), addr: alu_rd_i, data: alu_data_i});
    end else if (el) begin
      exp_q.push_back('{en: (lsu_rd_i != 0), addr: lsu_rd_i, data: lsu_data_i});
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_en", wr_en_o, e.en);
      chk("wr_addr", wr_addr_o, e.addr);
      chk("wr_data", wr_data_o, e.data);
      hold_addr = e.addr;
      hold_data = e.data;
    end else begin
      chk("wr_en_idle", wr_en_o, 1'b0);
      chk("wr_addr_hold", wr_addr_o, hold_addr);
      chk("wr_data_hold", wr_data_o, hold_data);
    end
  endtask

  initial begin
`ifdef SB_EARLY_CLEAR_EN
    early_exp = 1'b1;
`else
    early_exp = 1'b0;
`endif
    vecs[0] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0};
    vecs[4] = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 32'hAA, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'hBB, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  1'b0, 1'b0};

    // Reset and idle
    do_reset();
    #1;
    chk("reset_wr_en", wr_en_o, 1'b0);
    chk("reset_wr_addr", wr_addr_o, 5'd0);
    chk("reset_wr_data", wr_data_o, 32'h0);
    chk("reset_err", err_o, 1'b0);
    chk("reset_ready", issue_ready_o, 1'b1);
    cyc(1'b0, 1'b0);

    // Long load to x5, dependent stalls until the LSU returns
    issue_valid_i = 1'b1; issue_long_i = 1'b1; issue_rd_i = 5'd5;
    chk_ready("long_rd5_ready", 1'b1);
    cyc(1'b0, 1'b0);
    issue_long_i = 1'b0; issue_rs1_i = 5'd5; issue_rd_i = 5'd7;
    chk_ready("raw_rs1_5_stall", 1'b0);
    cyc(1'b0, 1'b0);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd5; lsu_data_i = 32'hDEADBEEF;
    chk_ready("raw_grant_cycle", early_exp);
    cyc(1'b0, 1'b1);
    lsu_valid_i = 1'b0;
    chk_ready("raw_after_grant", 1'b1);
    chk("no_err_normal_load", err_o, 1'b0);
    issue_valid_i = 1'b0;
    cyc(1'b0, 1'b0);

    // Asynchronous reset mid-load discards busy state
    issue_valid_i = 1'b1; issue_long_i = 1'b1; issue_rs1_i = 5'd0; issue_rd_i = 5'd5;
    cyc(1'b0, 1'b0);
    issue_long_i = 1'b0; issue_rs1_i = 5'd5; issue_rd_i = 5'd7;
    chk_ready("midload_stall", 1'b0);
    rst = 1'b1;
    #1;
    chk("midload_rst_ready", issue_ready_o, 1'b1);
    chk("midload_rst_wr_data", wr_data_o, 32'h0);
    #1 rst = 1'b0;
    exp_q.delete();
    hold_addr = '0;
    hold_data = '0;
    chk_ready("midload_post_rst_ready", 1'b1);
    issue_valid_i = 1'b0;
    cyc(1'b0, 1'b0);

    // Arbitration table from reset
    do_reset();
    for (int i = 0; i < 7; i++) begin
      alu_valid_i = vecs[i].av; alu_rd_i = vecs[i].ard; alu_data_i = vecs[i].ad;
      lsu_valid_i = vecs[i].lv; lsu_rd_i = vecs[i].lrd; lsu_data_i = vecs[i].ld;
      cyc(vecs[i].ea, vecs[i].el);
    end
    clear_inputs();
    #1 chk("arb_underflow_err", err_o, 1'b1);

    // Underflow, then pending limit and simultaneous inc/dec
    do_reset();
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd12; lsu_data_i = 32'h5A;
    cyc(1'b0, 1'b1);
    lsu_valid_i = 1'b0;
    #1 chk("underflow_err", err_o, 1'b1);
    for (int r = 1; r <= 4; r++) begin
      issue_valid_i = 1'b1; issue_long_i = 1'b1; issue_rd_i = 5'(r);
      chk_ready($sformatf("long_issue_%0d", r), 1'b1);
      cyc(1'b0, 1'b0);
    end
    issue_rd_i = 5'd9;
    chk_ready("fifth_long_blocked", 1'b0);
    issue_long_i = 1'b0; issue_rd_i = 5'd6;
    chk_ready("short_while_full", 1'b1);
    issue_valid_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd1; lsu_data_i = 32'h1;
    cyc(1'b0, 1'b1);
    lsu_rd_i = 5'd2; lsu_data_i = 32'h2;
    issue_valid_i = 1'b1; issue_long_i = 1'b1; issue_rd_i = 5'd7;
    chk_ready("inc_dec_issue", 1'b1);
    cyc(1'b0, 1'b1);
    lsu_valid_i = 1'b0;
    issue_rd_i = 5'd8;
    chk_ready("refill_to_max", 1'b1);
    cyc(1'b0, 1'b0);
    issue_rd_i = 5'd9;
    chk_ready("full_again_blocked", 1'b0);
    issue_long_i = 1'b0; issue_rs2_i = 5'd3; issue_rd_i = 5'd6;
    chk_ready("raw_rs2_busy3", 1'b0);
    issue_rs2_i = 5'd0; issue_rs1_i = 5'd8;
    chk_ready("raw_rs1_busy8", 1'b0);
    issue_rs1_i = 5'd0; issue_rd_i = 5'd1;
    chk_ready("cleared_rd1_ready", 1'b1);
    issue_valid_i = 1'b0;
    cyc(1'b0, 1'b0);
    chk("err_sticky", err_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
